// File: rtl/frame_loader.sv
// Fixed-length frame loader: writes DATA_W-wide stream bytes into a NUM_BANKS ring of frame buffers.
// Each frame must end with an END1/END2 trailer. Define FRAME_CHECKSUM_EN to expect a sum byte before the trailer.
module frame_loader #(
  parameter int                DATA_W     = 8,
  parameter int                FRAME_SIZE = 784,
  parameter int                ADDR_W     = 10,
  parameter int                NUM_BANKS  = 2,
  parameter logic [DATA_W-1:0] END1       = 'h66,
  parameter logic [DATA_W-1:0] END2       = 'hBB,
  localparam int               BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int               CNT_W      = $clog2(NUM_BANKS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_ready,
  input  logic              bank_release,
  output logic [BANK_W-1:0] wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_en,
  output logic              frame_done,
  output logic [BANK_W-1:0] done_bank,
  output logic [CNT_W-1:0]  banks_ready,
  output logic              frame_err,
  output logic [1:0]        err_code
);

  localparam int BCNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_RECV,
`ifdef FRAME_CHECKSUM_EN
    S_CHK,
`endif
    S_TRL1,
    S_TRL2,
    S_HUNT
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_TRAILER  = 2'd1,
    ERR_OVERRUN  = 2'd2,
    ERR_CHECKSUM = 2'd3
  } err_e;

  state_e            r_state,     w_state_nxt;
  logic [BCNT_W-1:0] r_byte_cnt,  w_cnt_nxt;
  logic [BANK_W-1:0] r_wr_bank,   w_bank_nxt;
  logic [BANK_W-1:0] r_rd_ptr,    w_rd_ptr_nxt;
  logic [CNT_W-1:0]  r_banks_ready, w_ready_nxt;
  logic              r_hunt_end1, w_hunt_nxt;
  logic [ADDR_W-1:0] r_wr_addr,   w_addr_nxt;
  logic [DATA_W-1:0] r_wr_data,   w_data_nxt;
  logic              r_wr_en,     w_wr_en_nxt;
  logic              r_frame_done, w_done_nxt;
  logic [BANK_W-1:0] r_done_bank, w_done_bank_nxt;
  logic              r_frame_err, w_err_nxt;
  err_e              r_err_code,  w_code_nxt;
  logic              w_commit;
  logic              w_release;
  logic [BANK_W-1:0] w_bank_inc;
`ifdef FRAME_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum, w_sum_nxt;
`endif

  assign w_bank_inc = (r_wr_bank == BANK_W'(NUM_BANKS - 1)) ? '0 : r_wr_bank + BANK_W'(1);

  // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_byte_cnt;
    w_bank_nxt      = r_wr_bank;
    w_hunt_nxt      = r_hunt_end1;
    w_addr_nxt      = r_wr_addr;
    w_data_nxt      = r_wr_data;
    w_wr_en_nxt     = 1'b0;
    w_done_nxt      = 1'b0;
    w_done_bank_nxt = r_done_bank;
    w_err_nxt       = 1'b0;
    w_code_nxt      = r_err_code;
    w_commit        = 1'b0;
`ifdef FRAME_CHECKSUM_EN
    w_sum_nxt       = r_sum;
`endif
    if (!enable) begin
      // Dropping enable abandons the partial frame quietly; bank bookkeeping survives.
      w_state_nxt = S_RECV;
      w_cnt_nxt   = '0;
      w_hunt_nxt  = 1'b0;
    end else if (rx_ready) begin
      unique case (r_state)
        S_RECV: begin
          if (r_byte_cnt == '0 && r_banks_ready == CNT_W'(NUM_BANKS)) begin
            w_err_nxt   = 1'b1;
            w_code_nxt  = ERR_OVERRUN;
            w_state_nxt = S_HUNT;
            w_hunt_nxt  = 1'b0;
          end else begin
            w_wr_en_nxt = 1'b1;
            w_addr_nxt  = r_byte_cnt[ADDR_W-1:0];
            w_data_nxt  = rx_data;
            w_cnt_nxt   = r_byte_cnt + BCNT_W'(1);
`ifdef FRAME_CHECKSUM_EN
            w_sum_nxt   = ((r_byte_cnt == '0) ? '0 : r_sum) + rx_data;
            if (r_byte_cnt == BCNT_W'(FRAME_SIZE - 1)) w_state_nxt = S_CHK;
`else
            if (r_byte_cnt == BCNT_W'(FRAME_SIZE - 1)) w_state_nxt = S_TRL1;
`endif
          end
        end
`ifdef FRAME_CHECKSUM_EN
        S_CHK: begin
          if (rx_data == r_sum) begin
            w_state_nxt = S_TRL1;
          end else begin
            w_err_nxt   = 1'b1;
            w_code_nxt  = ERR_CHECKSUM;
            w_state_nxt = S_HUNT;
            w_hunt_nxt  = 1'b0;
            w_cnt_nxt   = '0;
          end
        end
`endif
        S_TRL1: begin
          if (rx_data == END1) begin
            w_state_nxt = S_TRL2;
          end else begin
            w_err_nxt   = 1'b1;
            w_code_nxt  = ERR_TRAILER;
            w_state_nxt = S_HUNT;
            w_hunt_nxt  = 1'b0;
            w_cnt_nxt   = '0;
          end
        end
        S_TRL2: begin
          if (rx_data == END2) begin
            w_commit        = 1'b1;
            w_done_nxt      = 1'b1;
            w_done_bank_nxt = r_wr_bank;
            w_bank_nxt      = w_bank_inc;
            w_cnt_nxt       = '0;
            w_state_nxt     = S_RECV;
          end else begin
            w_err_nxt   = 1'b1;
            w_code_nxt  = ERR_TRAILER;
            w_state_nxt = S_HUNT;
            w_hunt_nxt  = 1'b0;
            w_cnt_nxt   = '0;
          end
        end
        S_HUNT: begin
          if (r_hunt_end1 && rx_data == END2) begin
            w_state_nxt = S_RECV;
            w_cnt_nxt   = '0;
            w_hunt_nxt  = 1'b0;
          end else begin
            w_hunt_nxt = (rx_data == END1);
          end
        end
        default: w_state_nxt = S_RECV;
      endcase
    end
  end

  // A release and a commit landing on the same edge cancel out; a release at zero is dropped.
  always_comb begin
    w_release    = bank_release && (r_banks_ready != '0);
    w_ready_nxt  = r_banks_ready;
    w_rd_ptr_nxt = r_rd_ptr;
    if (w_commit && !w_release)      w_ready_nxt = r_banks_ready + CNT_W'(1);
    else if (!w_commit && w_release) w_ready_nxt = r_banks_ready - CNT_W'(1);
    if (w_release)
      w_rd_ptr_nxt = (r_rd_ptr == BANK_W'(NUM_BANKS - 1)) ? '0 : r_rd_ptr + BANK_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_RECV;
      r_byte_cnt    <= '0;
      r_wr_bank     <= '0;
      r_rd_ptr      <= '0;
      r_banks_ready <= '0;
      r_hunt_end1   <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_wr_en       <= 1'b0;
      r_frame_done  <= 1'b0;
      r_done_bank   <= '0;
      r_frame_err   <= 1'b0;
      r_err_code    <= ERR_NONE;
`ifdef FRAME_CHECKSUM_EN
      r_sum         <= '0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_byte_cnt    <= w_cnt_nxt;
      r_wr_bank     <= w_bank_nxt;
      r_rd_ptr      <= w_rd_ptr_nxt;
      r_banks_ready <= w_ready_nxt;
      r_hunt_end1   <= w_hunt_nxt;
      r_wr_addr     <= w_addr_nxt;
      r_wr_data     <= w_data_nxt;
      r_wr_en       <= w_wr_en_nxt;
      r_frame_done  <= w_done_nxt;
      r_done_bank   <= w_done_bank_nxt;
      r_frame_err   <= w_err_nxt;
      r_err_code    <= w_code_nxt;
`ifdef FRAME_CHECKSUM_EN
      r_sum         <= w_sum_nxt;
`endif
    end
  end

  assign wr_bank     = r_wr_bank;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign wr_en       = r_wr_en;
  assign frame_done  = r_frame_done;
  assign done_bank   = r_done_bank;
  assign banks_ready = r_banks_ready;
  assign frame_err   = r_frame_err;
  assign err_code    = r_err_code;

endmodule

// File: tb/tb_frame_loader.sv
// Self-checking bench for frame_loader: vector table, directed frame sequences, then randomized streams
// compared every cycle against a position-based stream model. Honours FRAME_CHECKSUM_EN like the design.
`timescale 1ns/1ps
module tb_frame_loader;

  localparam int FS = 784;
  localparam int NB = 2;
  localparam logic [7:0] END1 = 8'h66;
  localparam logic [7:0] END2 = 8'hBB;
`ifdef FRAME_CHECKSUM_EN
  localparam int TRL_POS = FS + 1;
`else
  localparam int TRL_POS = FS;
`endif

  logic       clk = 1'b0;
  logic       rst, enable, rx_ready, bank_release;
  logic [7:0] rx_data;
  logic [0:0] wr_bank, done_bank;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_en, frame_done, frame_err;
  logic [1:0] banks_ready, err_code;

  frame_loader dut (
    .clk(clk), .rst(rst), .enable(enable), .rx_data(rx_data), .rx_ready(rx_ready),
    .bank_release(bank_release), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_en(wr_en), .frame_done(frame_done), .done_bank(done_bank), .banks_ready(banks_ready),
    .frame_err(frame_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_wr    = 0;
  bit g_rand  = 1'b0;

  // Reference model: position within the current frame attempt, plus hunt status.
  int m_pos, m_bank, m_ready, m_done_bank, m_code, m_sum;
  bit m_hunt, m_seen;
  bit e_wr, e_done, e_err;
  int e_addr, e_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_bank = 0; m_ready = 0; m_done_bank = 0; m_code = 0; m_sum = 0;
    m_hunt = 0; m_seen = 0; e_wr = 0; e_done = 0; e_err = 0; e_addr = 0; e_data = 0;
  endtask

  task automatic model_fail(input int code);
    e_err = 1; m_code = code; m_hunt = 1; m_seen = 0; m_pos = 0;
  endtask

  task automatic model_update(input bit en, input bit rdy, input logic [7:0] d, input bit rel);
    int  old_ready = m_ready;
    bit  commit = 0;
    e_wr = 0; e_done = 0; e_err = 0;
    if (!en) begin
      m_pos = 0; m_hunt = 0; m_seen = 0;
    end else if (rdy) begin
      if (m_hunt) begin
        if (m_seen && d == END2) begin m_hunt = 0; m_seen = 0; m_pos = 0; end
        else m_seen = (d == END1);
      end else if (m_pos == 0 && m_ready == NB) begin
        model_fail(2);
      end else if (m_pos < FS) begin
        if (m_pos == 0) m_sum = 0;
        e_wr = 1; e_addr = m_pos; e_data = int'(d);
        m_sum = (m_sum + int'(d)) % 256;
        m_pos++;
`ifdef FRAME_CHECKSUM_EN
      end else if (m_pos == FS) begin
        if (int'(d) == m_sum) m_pos++;
        else model_fail(3);
`endif
      end else if (m_pos == TRL_POS) begin
        if (d == END1) m_pos++;
        else model_fail(1);
      end else begin
        if (d == END2) begin
          commit = 1; e_done = 1; m_done_bank = m_bank;
          m_bank = (m_bank + 1) % NB; m_pos = 0;
        end else model_fail(1);
      end
    end
    if (commit) m_ready++;
    if (rel && old_ready > 0) m_ready--;
  endtask

  task automatic compare_outputs();
    check("wr_en", wr_en, e_wr);
    if (e_wr) begin
      check("wr_addr", wr_addr, e_addr);
      check("wr_data", wr_data, e_data);
    end
    if (wr_en === 1'b1) n_wr++;
    check("wr_bank", wr_bank, m_bank);
    check("frame_done", frame_done, e_done);
    check("done_bank", done_bank, m_done_bank);
    check("frame_err", frame_err, e_err);
    check("err_code", err_code, m_code);
    check("banks_ready", banks_ready, m_ready);
  endtask

  // Called at a negedge: drive, let the posedge capture, then compare at the next negedge.
  task automatic step(input bit en, input bit rdy, input logic [7:0] d, input bit rel);
    enable = en; rx_ready = rdy; rx_data = d; bank_release = rel;
    model_update(en, rdy, d, rel);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic send_byte(input logic [7:0] d, input bit rel);
    if (g_rand)
      while ($urandom_range(0, 7) == 0) step(1, 0, 8'h00, $urandom_range(0, 511) == 0);
    step(1, 1, d, rel | (g_rand && $urandom_range(0, 511) == 0));
  endtask

  // mode: 0 good frame, 1 bad second trailer byte, 2 bad checksum byte (checksum builds only)
  task automatic send_frame(input int mode, input int mark, input bit rel_last);
    int sum = 0;
    logic [7:0] d;
    for (int i = 0; i < FS; i++) begin
      d = g_rand ? 8'($urandom) : 8'(i);
      if (i == mark) d = END1;
      sum = (sum + int'(d)) % 256;
      send_byte(d, 1'b0);
    end
`ifdef FRAME_CHECKSUM_EN
    send_byte((mode == 2) ? 8'(sum + 1) : 8'(sum), 1'b0);
`else
    if (mode == 2) sum = 0;
`endif
    send_byte(END1, 1'b0);
    send_byte((mode == 1) ? 8'h00 : END2, rel_last);
  endtask

  task automatic do_reset();
    enable = 0; rx_ready = 0; rx_data = 0; bank_release = 0; rst = 1;
    @(negedge clk); @(negedge clk);
    rst = 0;
    model_reset();
    check("rst_wr_en", wr_en, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_wr_bank", wr_bank, 0);
    check("rst_banks_ready", banks_ready, 0);
  endtask

  typedef struct {
    bit en; bit rdy; logic [7:0] d; bit rel;
    bit x_wr; int x_addr; bit x_err; int x_ready;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int k, n;
    tbl[0] = '{0, 1, 8'hAA, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 8'h00, 1, 0, 0, 0, 0};
    tbl[2] = '{1, 0, 8'h00, 1, 0, 0, 0, 0};
    tbl[3] = '{1, 1, 8'h5A, 0, 1, 0, 0, 0};
    tbl[4] = '{1, 1, 8'h66, 0, 1, 1, 0, 0};
    tbl[5] = '{1, 0, 8'h00, 0, 0, 0, 0, 0};
    tbl[6] = '{0, 1, 8'h01, 0, 0, 0, 0, 0};
    tbl[7] = '{1, 1, 8'h07, 0, 1, 0, 0, 0};

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].en, tbl[i].rdy, tbl[i].d, tbl[i].rel);
      check("tbl_wr_en", wr_en, tbl[i].x_wr);
      if (tbl[i].x_wr) check("tbl_addr", wr_addr, tbl[i].x_addr);
      check("tbl_err", frame_err, tbl[i].x_err);
      check("tbl_ready", banks_ready, tbl[i].x_ready);
    end
    step(0, 0, 8'h00, 0);

    // Basic frame into bank 0
    n_wr = 0;
    send_frame(0, -1, 0);
    check("t1_writes", n_wr, FS);
    check("t1_done_bank", done_bank, 0);
    check("t1_ready", banks_ready, 1);
    check("t1_wr_bank", wr_bank, 1);

    // END1 value inside the data region is plain data
    send_frame(0, 500, 0);
    check("t2_done_bank", done_bank, 1);
    check("t2_ready", banks_ready, 2);
    step(1, 0, 8'h00, 1);
    step(1, 0, 8'h00, 1);
    check("t2_ready_released", banks_ready, 0);

    // Bad trailer, hunt, resync
    send_frame(1, -1, 0);
    check("t3_err_code", err_code, 1);
    check("t3_wr_bank_kept", wr_bank, 0);
    send_byte(END1, 0);
    send_byte(END2, 0);
    send_frame(0, -1, 0);
    check("t3_done_bank", done_bank, 0);

    // Reset mid-frame, then overrun
    for (int i = 0; i < 300; i++) send_byte(8'(i), 0);
    do_reset();
    send_frame(0, -1, 0);
    send_frame(0, -1, 0);
    check("t4_full", banks_ready, 2);
    n_wr = 0;
    send_byte(8'h12, 0);
    check("t4_err_code", err_code, 2);
    check("t4_no_write", n_wr, 0);
    step(1, 0, 8'h00, 1);
    send_byte(END1, 0);
    send_byte(END2, 0);
    send_frame(0, -1, 0);
    check("t4_done_bank", done_bank, 0);
    check("t4_ready", banks_ready, 2);

    // Release coincident with commit, and release at zero
    step(1, 0, 8'h00, 1);
    send_frame(0, -1, 1);
    check("t5_net_zero", banks_ready, 1);
    step(1, 0, 8'h00, 1);
    step(1, 0, 8'h00, 1);
    check("t5_release_at_zero", banks_ready, 0);

    // Enable drop mid-frame
    for (int i = 0; i < 300; i++) send_byte(8'(i), 0);
    step(0, 0, 8'h00, 0);
    step(0, 1, 8'h44, 0);
    n_wr = 0;
    send_frame(0, -1, 0);
    check("t6_writes", n_wr, FS);
    check("t6_ready", banks_ready, 1);

`ifdef FRAME_CHECKSUM_EN
    send_frame(2, -1, 0);
    check("t7_err_code", err_code, 3);
    send_byte(END1, 0);
    send_byte(END2, 0);
`endif

    // Randomized streams
    g_rand = 1'b1;
    for (int it = 0; it < 14; it++) begin
      k = $urandom_range(0, 5);
      case (k)
        0, 1: send_frame(0, -1, $urandom_range(0, 1) == 0);
        2:    send_frame(1 + $urandom_range(0, 1), -1, 0);
        3: begin
          n = $urandom_range(1, 10);
          for (int j = 0; j < n; j++)
            send_byte(($urandom_range(0, 2) == 0) ? END1 : 8'($urandom), 0);
        end
        4: begin send_byte(END1, 0); send_byte(END2, 0); end
        default: begin
          n = $urandom_range(1, 400);
          for (int j = 0; j < n; j++) send_byte(8'($urandom), 0);
          step(0, 0, 8'h00, 0);
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_loader.md
Name: frame_loader

Overview:
- Parametrised successor to the single-image UART loader.
- Receives routed stream bytes from uart_router and writes fixed-length frames into a NUM_BANKS-deep ring of frame buffers (ping-pong by default).
- Validates the END1/END2 trailer at an exact byte position and resynchronises after errors.
- Applies back-pressure bookkeeping so inference can consume one bank while the next frame loads.

Parameters:
- DATA_W, 8, stream/pixel byte width
- FRAME_SIZE, 784, data bytes per frame
- ADDR_W, 10, RAM address width; must satisfy 2**ADDR_W >= FRAME_SIZE
- NUM_BANKS, 2, frame buffers in ring (>=1); BANK_W = max(1,$clog2(NUM_BANKS)), CNT_W = $clog2(NUM_BANKS+1) as localparams
- END1, 8'h66, first trailer byte
- END2, 8'hBB, second trailer byte

Ports:
- clk  in  1  system clock
- rst  in  1  reset (one clock; reset is synchronous and active-high)
- enable  in  1  accept bytes only when high (tied to weights_loaded)
- rx_data  in  DATA_W  routed RX byte
- rx_ready  in  1  one-cycle strobe, rx_data valid
- bank_release  in  1  consumer frees oldest filled bank (pulse)
- wr_bank  out  BANK_W  bank being written
- wr_addr  out  ADDR_W  address within bank
- wr_data  out  DATA_W  write data
- wr_en  out  1  write strobe
- frame_done  out  1  one-cycle pulse, frame committed
- done_bank  out  BANK_W  bank just committed (valid with frame_done, held until next)
- banks_ready  out  CNT_W  filled, unreleased banks
- frame_err  out  1  one-cycle error pulse
- err_code  out  2  0 none, 1 bad trailer, 2 overrun, 3 checksum; held until next frame_err

Behaviour:
- Reset: state=RECV, byte_cnt=0, wr_bank=0, rd-ring pointer=0, banks_ready=0, all outputs 0.
- wr_en, frame_done and frame_err default 0 every cycle and are registered: asserted exactly one cycle after the causing rx_ready.
- enable=0: rx_ready ignored. Falling enable aborts any partial frame: state=RECV, byte_cnt=0, no error. wr_bank and banks_ready are kept.
- RECV, rx_ready:
  - byte_cnt==0 and banks_ready==NUM_BANKS: overrun. Set frame_err, err_code=2, go to HUNT; the byte is not written.
  - otherwise: wr_addr=byte_cnt, wr_data=rx_data, wr_en=1, byte_cnt+1.
  - byte_cnt reaching FRAME_SIZE: go to TRL1.
  - The data region is written blindly; END1/END2 values inside it are plain data.
- TRL1, rx_ready: rx_data==END1 goes to TRL2; otherwise bad trailer.
- TRL2, rx_ready: rx_data==END2 commits the frame:
  - frame_done=1, done_bank=wr_bank.
  - wr_bank advances modulo NUM_BANKS.
  - banks_ready+1, byte_cnt=0, back to RECV.
  - otherwise bad trailer.
- Bad trailer: frame_err=1, err_code=1, go to HUNT. The bank is not committed and wr_bank is unchanged, so the next frame overwrites it.
- HUNT: discard bytes until an END1 byte is immediately followed by an END2 byte. Then byte_cnt=0 and return to RECV, with no pulse. A second END1 in HUNT keeps the END1-seen flag set.
- bank_release: decrements banks_ready when nonzero; ignored when 0.
- bank_release coincident with frame_done: banks_ready unchanged (net 0).
- rx_ready coincident with bank_release on an overrun check: the check uses the pre-release banks_ready.
- rst mid-frame: everything cleared; partial data is abandoned.
- byte_cnt is ADDR_W+1 bits; no wrap inside a frame.

Optional Feature:
- FRAME_CHECKSUM_EN defined:
  - Stream is FRAME_SIZE data, CHK, END1, END2.
  - A running DATA_W-bit modulo-2**DATA_W sum covers the data bytes; it clears when a frame starts.
  - A CHK state sits between RECV and TRL1.
  - Mismatch: frame_err, err_code=3, go to HUNT, no commit.
  - A matching CHK goes to TRL1.
- Undefined: no CHK state, no sum register, err_code 3 is never produced.

Test Plan:
- Defaults, enable=1, send 784 bytes (value = index mod 256), then 0x66 0xBB -> 784 wr_en pulses with addr 0..783 on bank 0; frame_done one cycle after 0xBB; done_bank=0; banks_ready=1; wr_bank=1.
- Frame with 0x66 at data index 500, plus valid trailer -> byte 500 written as 0x66; frame commits normally.
- 784 bytes then 0x66 0x00 -> frame_err with err_code=1; no frame_done. Next 0x66 0xBB ends HUNT; a following good frame commits to bank 0.
- Two good frames with no release, then a third frame's first byte -> frame_err with err_code=2, no wr_en. Then bank_release, 0x66 0xBB, good frame -> commits to bank 0; banks_ready=2.
- bank_release in the same cycle as frame_done with banks_ready=1 -> banks_ready stays 1. bank_release with banks_ready=0 -> stays 0.
- enable dropped after 300 bytes, re-raised, good frame sent -> addresses restart at 0, no frame_err. Under FRAME_CHECKSUM_EN, a wrong CHK -> err_code=3.
